// File: rtl/conv_pkg.sv
// Shared FP16 types, constants and arithmetic primitives for the convolution datapath.
// Subnormal operands are treated as zero; rounding is round-to-nearest-even.
package conv_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_QNAN = 16'h7E00;

  function automatic int unsigned tree_depth(input int unsigned k);
    return $clog2(k * k);
  endfunction

  function automatic logic is_nan(input fp16_t f);
    return (f[14:10] == 5'h1f) && (f[9:0] != 10'h0);
  endfunction

  function automatic fp16_t mulfp16(input fp16_t a, input fp16_t b);
    logic        s;
    logic [21:0] p;
    logic [11:0] sig;
    logic        up;
    int          e;
    s = a[15] ^ b[15];
    if (is_nan(a)) return a;
    if (is_nan(b)) return b;
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) begin
      if (a[14:10] == 5'h0 || b[14:10] == 5'h0) return FP16_QNAN;
      return {s, 5'h1f, 10'h0};
    end
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0) return {s, 15'h0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) e = e + 1;
    else p = p << 1;
    up  = p[10] && ((|p[9:0]) || p[11]);
    sig = {1'b0, p[21:11]} + 12'(up);
    if (sig[11]) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 31) return {s, 5'h1f, 10'h0};
    if (e <= 0) return {s, 15'h0};
    return {s, 5'(e), sig[9:0]};
  endfunction

  function automatic fp16_t addfp16(input fp16_t a, input fp16_t b);
    fp16_t       x, y;
    logic [14:0] mx, my, r;
    logic [11:0] sig;
    logic        st, up;
    int          d, e;
    if (is_nan(a)) return a;
    if (is_nan(b)) return b;
    if (a[14:10] == 5'h1f) begin
      if (b[14:10] == 5'h1f && a[15] != b[15]) return FP16_QNAN;
      return a;
    end
    if (b[14:10] == 5'h1f) return b;
    if (a[14:10] == 5'h0 && b[14:10] == 5'h0) return {a[15] & b[15], 15'h0};
    if (a[14:10] == 5'h0) return b;
    if (b[14:10] == 5'h0) return a;
    // order by magnitude so the result sign is the larger operand's
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx = {2'b01, x[9:0], 3'b000};
    my = {2'b01, y[9:0], 3'b000};
    d  = int'(x[14:10]) - int'(y[14:10]);
    e  = int'(x[14:10]);
    if (d > 13) begin
      st = 1'b1;
      my = '0;
    end else begin
      st = |(my & ((15'd1 << d) - 15'd1));
      my = my >> d;
    end
    my = my | 15'(st);
    r  = (x[15] == y[15]) ? mx + my : mx - my;
    if (r == 15'h0) return FP16_ZERO;
    if (r[14]) begin
      r = {1'b0, r[14:1]} | 15'(r[0]);
      e = e + 1;
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (!r[13]) begin
          r = r << 1;
          e = e - 1;
        end
      end
    end
    up  = r[2] && ((|r[1:0]) || r[3]);
    sig = {1'b0, r[13:3]} + 12'(up);
    if (sig[11]) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 31) return {x[15], 5'h1f, 10'h0};
    if (e <= 0) return {x[15], 15'h0};
    return {x[15], 5'(e), sig[9:0]};
  endfunction

endpackage

// File: rtl/fp16_adder_tree.sv
// Combinational balanced FP16 reduction of N values; splits recursively into halves.
module fp16_adder_tree
  import conv_pkg::*;
#(
  parameter int unsigned N = 9
) (
  input  logic [N*16-1:0] data_i,
  output fp16_t           sum_o
);

  generate
    if (N == 1) begin : g_leaf
      assign sum_o = data_i;
    end else begin : g_split
      localparam int unsigned NL = N / 2;
      localparam int unsigned NR = N - NL;
      fp16_t sum_l, sum_r;
      fp16_adder_tree #(.N(NL)) u_lo (.data_i(data_i[NL*16-1:0]),    .sum_o(sum_l));
      fp16_adder_tree #(.N(NR)) u_hi (.data_i(data_i[N*16-1:NL*16]), .sum_o(sum_r));
      assign sum_o = addfp16(sum_l, sum_r);
    end
  endgenerate

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming FP16 KxK convolution: column-shifted kernel and window, strided emit,
// then a three-stage multiply / adder-tree / bias+ReLU pipeline under one stall.
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                              in_kernel,
  input  logic                              in_sor,
  input  logic [DATA_WIDTH-1:0]             bias_in,
  input  logic                              relu_en,
  output logic                              kernel_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data
);

  localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned CW = $clog2(KERNEL_SIZE + 1);
  localparam int unsigned SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned COLW = KERNEL_SIZE * DATA_WIDTH;

  logic [COLW-1:0]  kern_q [KERNEL_SIZE];
  logic [COLW-1:0]  kern_d [KERNEL_SIZE];
  logic [COLW-1:0]  win_q  [KERNEL_SIZE];
  logic [COLW-1:0]  win_d  [KERNEL_SIZE];
  logic [CW-1:0]    kcnt_q, kcnt_d, fill_q, fill_d;
  logic [SW-1:0]    stride_q, stride_d;
  logic             kready_q, emit_c, stall_c, acc_img_c, acc_ker_c;
  logic             v0_q, v1_q, v2_q, out_valid_q;
  logic [KK*16-1:0] prod_q, prod_c;
  fp16_t            sum_q, sum_c, biased_c, res_c, out_data_q;

  assign stall_c      = out_valid_q && !out_ready;
  assign in_ready     = !stall_c;
  assign acc_img_c    = in_valid && !stall_c && !in_kernel;
  assign acc_ker_c    = in_valid && !stall_c && in_kernel;
  assign kernel_ready = kready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;

  // Column shift of kernel/window plus fill and stride bookkeeping.
  always_comb begin
    kern_d   = kern_q;
    win_d    = win_q;
    kcnt_d   = kcnt_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    emit_c   = 1'b0;
    if (acc_ker_c) begin
      for (int unsigned c = 0; c + 1 < KERNEL_SIZE; c++) kern_d[c] = kern_q[c+1];
      kern_d[KERNEL_SIZE-1] = in_data;
      if (kcnt_q != CW'(KERNEL_SIZE)) kcnt_d = kcnt_q + CW'(1);
    end
    if (acc_img_c) begin
      for (int unsigned c = 0; c + 1 < KERNEL_SIZE; c++) win_d[c] = win_q[c+1];
      win_d[KERNEL_SIZE-1] = in_data;
      if (in_sor) fill_d = CW'(1);
      else if (fill_q != CW'(KERNEL_SIZE)) fill_d = fill_q + CW'(1);
      if (fill_d == CW'(KERNEL_SIZE)) begin
        if (in_sor || fill_q != CW'(KERNEL_SIZE) || stride_q == SW'(STRIDE - 1)) begin
          emit_c   = kready_q;
          stride_d = '0;
        end else begin
          stride_d = stride_q + SW'(1);
        end
      end else if (in_sor) begin
        stride_d = '0;
      end
    end
  end

  always_comb begin
    prod_c = '0;
    for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
      for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
        prod_c[(c*KERNEL_SIZE+j)*16 +: 16] =
          mulfp16(win_q[c][j*DATA_WIDTH +: 16], kern_q[c][j*DATA_WIDTH +: 16]);
      end
    end
  end

  fp16_adder_tree #(.N(KK)) u_tree (.data_i(prod_q), .sum_o(sum_c));

  // NaN keeps its sign bit through ReLU; only real negatives clamp to +0.
  always_comb begin
    biased_c = addfp16(sum_q, fp16_t'(bias_in));
    res_c    = (relu_en && biased_c[15] && !is_nan(biased_c)) ? FP16_ZERO : biased_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
        kern_q[c] <= '0;
        win_q[c]  <= '0;
      end
      kcnt_q      <= '0;
      kready_q    <= 1'b0;
      fill_q      <= '0;
      stride_q    <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      sum_q       <= FP16_ZERO;
      out_data_q  <= FP16_ZERO;
    end else begin
      kern_q   <= kern_d;
      win_q    <= win_d;
      kcnt_q   <= kcnt_d;
      kready_q <= (kcnt_d == CW'(KERNEL_SIZE));
      fill_q   <= fill_d;
      stride_q <= stride_d;
      if (!stall_c) begin
        v0_q        <= emit_c;
        v1_q        <= v0_q;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        if (v0_q) prod_q <= prod_c;
        if (v1_q) sum_q <= sum_c;
        if (v2_q) out_data_q <= res_c;
      end
    end
  end

endmodule

// File: doc/conv_kxk_stream.md
Name: conv_kxk_stream

Overview:
Parametrised streaming FP16 KxK convolution engine, the successor to the fixed 3x3 column-fed conv unit. It adds generic KERNEL_SIZE and column stride, window-fill tracking per row, optional bias add and ReLU, and a full valid/ready handshake on both sides. It sits between the line-buffer column feeder and the pooling/activation stage of a CNN layer.

Parameters:
DATA_WIDTH, 16, element width; fixed at 16 because the arithmetic is FP16 via the mulfp16/addfp16 primitives.
KERNEL_SIZE, 3, kernel edge K; legal range 1..5.
STRIDE, 1, horizontal stride in columns; legal range 1..K.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input column valid.
in_ready  out  1  block accepts the column this cycle.
in_data  in  K*16  one column, element j at bits [16j+15:16j].
in_kernel  in  1  column is kernel data (1) or image data (0); qualified by in_valid.
in_sor  in  1  start-of-row; image column is column 0 of a new row.
bias_in  in  16  FP16 bias; static while the block is not idle.
relu_en  in  1  clamp negative results to +0; static while the block is not idle.
kernel_ready  out  1  K kernel columns loaded since reset.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  16  FP16 result.

Behaviour:
- Reset: in_ready=1 after reset deasserts. out_valid=0, out_data=0, kernel_ready=0. Window, kernel, counters and all pipe valids cleared. Reset mid-stream drops everything in flight.
- Accept = in_valid && in_ready. stall = out_valid && !out_ready. in_ready = !stall. Every stage advances only when !stall.
- Kernel accept: shift the kernel column-wise; the new column enters position K-1. A 0..K counter saturates at K and sets kernel_ready. Kernel columns never produce output. Reloading is allowed at any time; products already registered keep the old weights.
- Image accept: shift the window the same way.
  - fill_cnt: reset to 1 if in_sor, else saturating increment to K.
  - Emit condition: fill_cnt reaches K (first window of the row), then every STRIDE further columns, tracked by stride_cnt, which restarts at in_sor.
  - Image columns accepted while kernel_ready=0 still shift the window but never emit.
- Pipeline, only for emitting windows:
  - S1: K*K products registered.
  - S2: balanced combinational addfp16 tree registered.
  - S3: add bias, apply ReLU (sign bit set gives 0x0000), register into out_data.
  - Latency: out_valid rises 3 cycles after the accepting edge when unstalled.
- Stall: out_data and out_valid hold stable until out_ready. No result is dropped or duplicated. Throughput is 1 column/cycle when out_ready=1.
- Simultaneous: out handshake completing while a new emit reaches S3 gives back-to-back results with out_valid staying 1.
- Arithmetic: FP16 adds happen in tree order, not sequential order. Bias is added last. -0 and NaN pass through the primitives unchanged; ReLU maps only sign=1 non-NaN values to 0x0000.

Decomposition:
- Package conv_pkg: FP16 typedef, FP16 constants (ZERO, ONE), and a function computing adder-tree depth from KERNEL_SIZE.
- One natural sub-module, fp16_adder_tree #(N): generic combinational reduction of N FP16 values, built from addfp16 and reused by later layers.

Test Plan:
- Load 3 kernel columns of 0x3C00; feed sor plus 3 image columns of 0x3C00 with bias 0 -> one out 0x4880 (9.0) exactly 3 cycles after the 3rd accept; kernel_ready rises after the 3rd kernel column.
- Same stimulus with bias_in=0xBC00 (-1.0) -> 0x4800 (8.0). Kernel all 0xBC00 with relu_en=1 -> 0x0000; with relu_en=0 -> 0xC880.
- STRIDE=2, K=3, 7-column row with sor on the first column -> exactly 3 outputs, at columns 3, 5, 7. A second row with sor -> no output until its 3rd column.
- Continuous input with out_ready low for 4 cycles mid-stream -> in_ready low during the stall, out_data constant, and the full result sequence matches the reference model with no loss or duplication.
- Image columns sent before the kernel is loaded -> no out_valid. Reload the kernel to 0x4000 mid-row -> subsequent windows of 1.0 give 0x4C80 (18.0).
- Assert rst for 1 cycle with 2 results in flight -> out_valid=0 and kernel_ready=0 the next cycle; no stale result emerges afterwards.
